// File: rtl/decoder_pipe_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pipe_pkg
// Shared constants and types for the registered one-hot decoder.
//   MAX_ADDR_W / MAX_STAGES : upper bounds used by the parameter range checks
//   decode_mode_t           : meaning of the STICKY parameter (pulse/accumulate)
//   mode_from_param()       : maps the integer STICKY parameter onto the enum
// -----------------------------------------------------------------------------
package decoder_pipe_pkg;

  localparam int MAX_ADDR_W = 8;
  localparam int MAX_STAGES = 3;

  typedef enum logic {
    MODE_PULSE  = 1'b0,
    MODE_STICKY = 1'b1
  } decode_mode_t;

  function automatic decode_mode_t mode_from_param(input int sticky);
    if (sticky != 0) begin
      return MODE_STICKY;
    end else begin
      return MODE_PULSE;
    end
  endfunction

endpackage

// File: rtl/decoder_stage.sv
// -----------------------------------------------------------------------------
// decoder_stage
// One pipeline register of the decoder: decoded vector plus its valid bit,
// cleared asynchronously while i_rst_n is low.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   i_d     : next value {valid, vector}
//   o_q     : registered value {valid, vector}
// -----------------------------------------------------------------------------
module decoder_stage
  import decoder_pipe_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Stage register with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= {W{1'b0}};
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/decoder_pipe.sv
// -----------------------------------------------------------------------------
// decoder_pipe
// Registered ADDR_W -> NUM_OUT one-hot decoder with enable, STAGES register
// stages of latency and either pulse or sticky (accumulating) output.
// Out-of-range indices (in >= NUM_OUT) decode to nothing; they never alias.
// Optional build macro DECODER_PIPE_ERR_EN adds the err output (one-cycle
// flag for out-of-range requests, aligned with out) and a one-hot-or-zero
// assertion on out in pulse mode.
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   enable    : request qualifier
//   in        : index to decode (unsigned)
//   clear     : sticky mode only, synchronous clear of accumulated bits
//   out       : one-hot (pulse) or accumulated (sticky) vector
//   out_valid : pulse: registered in-range request; sticky: OR of out
//   err       : (DECODER_PIPE_ERR_EN only) out-of-range request flag
// -----------------------------------------------------------------------------
module decoder_pipe
  import decoder_pipe_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int NUM_OUT = 32,
  parameter int STAGES  = 1,
  parameter int STICKY  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [ADDR_W-1:0]  in,
  input  logic               clear,
  output logic [NUM_OUT-1:0] out,
  output logic               out_valid
`ifdef DECODER_PIPE_ERR_EN
  ,
  output logic               err
`endif
);

  localparam decode_mode_t MODE = mode_from_param(STICKY);
  localparam int           SW   = NUM_OUT + 1;

  if ((ADDR_W < 1) || (ADDR_W > MAX_ADDR_W)) begin : g_bad_addr_w
    $error("decoder_pipe: ADDR_W out of range");
  end
  if ((NUM_OUT < 2) || (NUM_OUT > (1 << ADDR_W))) begin : g_bad_num_out
    $error("decoder_pipe: NUM_OUT out of range");
  end
  if ((STAGES < 1) || (STAGES > MAX_STAGES)) begin : g_bad_stages
    $error("decoder_pipe: STAGES out of range");
  end
  if ((STICKY != 0) && (STICKY != 1)) begin : g_bad_sticky
    $error("decoder_pipe: STICKY must be 0 or 1");
  end

  logic [NUM_OUT-1:0] w_dec;
  logic               w_in_range;
  logic               w_req_vld;
  logic [SW-1:0]      w_first;
  logic [SW-1:0]      w_last;
  logic [SW-1:0]      w_final_d;
  logic [NUM_OUT-1:0] w_acc;
  logic [SW-1:0]      w_stage_d [STAGES];
  logic [SW-1:0]      w_stage_q [STAGES];

  // Combinational decode; codes at or above NUM_OUT match no output bit.
  always_comb begin
    w_dec = {NUM_OUT{1'b0}};
    for (int i = 0; i < NUM_OUT; i++) begin
      w_dec[i] = enable && (in == ADDR_W'(i));
    end
  end

  assign w_in_range = (32'(in) < 32'(NUM_OUT));
  assign w_req_vld  = enable & w_in_range;
  assign w_first    = {w_req_vld, w_dec};

  // Stage chain: stage 0 takes the decode, the last stage takes w_final_d
  // (pass-through in pulse mode, accumulate in sticky mode).
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    decoder_stage #(.W(SW)) u_stage (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_d     (w_stage_d[s]),
      .o_q     (w_stage_q[s])
    );
    if (s == STAGES - 1) begin : g_final_in
      assign w_stage_d[s] = w_final_d;
    end else if (s == 0) begin : g_first_in
      assign w_stage_d[s] = w_first;
    end else begin : g_mid_in
      assign w_stage_d[s] = w_stage_q[s-1];
    end
  end

  // Vector entering the final stage: combinational decode for a single stage.
  if (STAGES == 1) begin : g_last_comb
    assign w_last = w_first;
  end else begin : g_last_reg
    assign w_last = w_stage_q[STAGES-2];
  end

  // Final-stage next value; clear drops old bits but a same-cycle arrival
  // is still captured.
  always_comb begin
    w_acc     = {NUM_OUT{1'b0}};
    w_final_d = w_last;
    if (MODE == MODE_STICKY) begin
      if (clear) begin
        w_acc = w_last[NUM_OUT-1:0];
      end else begin
        w_acc = w_stage_q[STAGES-1][NUM_OUT-1:0] | w_last[NUM_OUT-1:0];
      end
      w_final_d = {|w_acc, w_acc};
    end else begin
      w_final_d = w_last;
    end
  end

  assign out       = w_stage_q[STAGES-1][NUM_OUT-1:0];
  assign out_valid = w_stage_q[STAGES-1][NUM_OUT];

`ifdef DECODER_PIPE_ERR_EN
  logic              w_err_raw;
  logic [STAGES-1:0] r_err_sr;

  assign w_err_raw = enable & ~w_in_range;

  if (STAGES == 1) begin : g_err_one
    // Out-of-range flag register, same latency as out.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_err_sr <= 1'b0;
      end else begin
        r_err_sr <= w_err_raw;
      end
    end
  end else begin : g_err_multi
    // Out-of-range flag shift register, same latency as out.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_err_sr <= {STAGES{1'b0}};
      end else begin
        r_err_sr <= {r_err_sr[STAGES-2:0], w_err_raw};
      end
    end
  end

  assign err = r_err_sr[STAGES-1];

  if (MODE == MODE_PULSE) begin : g_onehot_chk
    a_onehot0 : assert property (@(posedge clk) disable iff (!reset) $onehot0(out))
      else $error("decoder_pipe: pulse output has more than one bit set");
  end
`endif

endmodule

// File: doc/decoder_pipe.md
Name: decoder_pipe

Overview:
- Parametrised, registered N-to-NUM_OUT one-hot decoder with enable.
- Successor to the 1-to-2 combinational decoder; used for register-file write-enable and bank-select generation in the pipelined CPU.
- Configurable pipeline depth and two output modes:
  - PULSE: one cycle per request.
  - STICKY: bits accumulate until cleared.
- Out-of-range indices are dropped rather than aliased.

Parameters:
ADDR_W, 5, index width in bits (1..8)
NUM_OUT, 32, number of decoded outputs (2..2**ADDR_W)
STAGES, 1, register stages from input to out (1..3)
STICKY, 0, 0 = pulse mode, 1 = sticky/accumulate mode

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-low reset; state cleared immediately while low
enable  input  1  request qualifier; decode only when 1
in  input  ADDR_W  index to decode
clear  input  1  STICKY mode: synchronous clear of accumulated bits; ignored when STICKY=0
out  output  NUM_OUT  decoded one-hot (PULSE) or accumulated (STICKY) vector
out_valid  output  1  PULSE: registered enable && in<NUM_OUT at output stage; STICKY: OR-reduction of out

Behaviour:
- Reset (reset low, async): all pipeline stages, out and out_valid are 0. No output for in-flight requests after release.
- Combinational decode: d[i] = enable && (in == i) for i < NUM_OUT.
  - Index in >= NUM_OUT yields d = 0; never wraps or aliases.
- Pipeline: d passes through STAGES registers with identical timing, no stalls.
  - A request at edge k appears on out after edge k+STAGES-1 completes (STAGES=1: visible the cycle after sampling).
  - Back-to-back requests are accepted every cycle; throughput 1/cycle.
- PULSE mode (STICKY=0):
  - out = final-stage register; at most one bit set.
  - Each request produces exactly one cycle of output.
  - enable=0 gives out=0 on the corresponding cycle.
- STICKY mode (STICKY=1):
  - Final register next = (clear ? 0 : out) | d_last, where d_last is the decoded vector from stage STAGES-1 (or from the combinational decode when STAGES=1).
  - clear and a same-cycle arriving request: clear wins for old bits; the new bit is set.
  - Repeated index: no change.
  - All NUM_OUT bits set: holds, no overflow.
  - clear has no pipeline delay.
- Width rules: in is compared unsigned at ADDR_W bits. NUM_OUT < 2**ADDR_W leaves the top codes unused.
- Reset asserted mid-stream: output cleared same instant; accumulated STICKY bits lost.

Optional Feature:
DECODER_PIPE_ERR_EN
- Defined:
  - Adds output port err (1 bit), reset 0.
  - err pulses high for one cycle, aligned with out timing (STAGES latency), when enable=1 and in >= NUM_OUT.
  - Adds a simulation assertion that PULSE-mode out is one-hot-or-zero every cycle.
- Undefined: no err port, no assertion. Out-of-range requests are silently dropped; behaviour otherwise identical.

Decomposition:
- Package decoder_pipe_pkg:
  - Constant MAX_ADDR_W = 8 and MAX_STAGES = 3, used for parameter range checks (elaboration-time $error on violation).
  - Enum decode_mode_t {MODE_PULSE, MODE_STICKY}, used for the STICKY parameter's meaning.
- Sub-module decoder_stage:
  - One NUM_OUT+1-bit register (vector plus valid) with async active-low reset.
  - Instantiated STAGES times via generate.
  - The STICKY accumulate logic stays in decoder_pipe.

Test Plan:
- Reset: hold reset=0 with enable=1, in=3 for 3 cycles -> out=0, out_valid=0. Release reset, enable=1, in=3 (STAGES=1, PULSE) -> next cycle out=32'h8, out_valid=1; following cycle (enable=0) out=0.
- Pipeline latency: STAGES=3, PULSE, requests in=0,1,31 on consecutive cycles -> out=32'h1, 32'h2, 32'h8000_0000 on cycles 3, 4, 5 after the first; one-hot each cycle.
- Out-of-range: ADDR_W=5, NUM_OUT=20, enable=1, in=25 -> out=0, out_valid=0. With DECODER_PIPE_ERR_EN defined -> err=1 for exactly one cycle at output latency.
- Sticky accumulate: STICKY=1, requests in=2, 5, 2 -> out=32'h24, out_valid=1. Then clear=1 together with request in=7 -> out=32'h80.
- Mid-stream reset: STAGES=2, request in=4 issued, reset pulsed low for half a cycle before output -> out stays 0, the request is never emitted, and the next request after release decodes normally.
- Exhaustive sweep: ADDR_W=3, NUM_OUT=8, all 8 indices with enable toggled -> out==(enable ? 1<<in : 0), delayed by STAGES, checked against a reference model.
